// File: rtl/yolo_video_pkg.sv
// Shared definitions for the YOLO video transmit path.
// Contents: FSM state type, raster timing helper functions and the
// default 640x480@60 timing constants used as parameter defaults.
package yolo_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } vtx_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;

  // Total clocks per line (or lines per frame).
  function automatic int timing_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

  // First counter value inside the sync pulse.
  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  // First counter value after the sync pulse (exclusive bound).
  function automatic int sync_end(input int act, input int fp, input int sw);
    return act + fp + sw;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position generator.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   run                : 1 = counters advance, 0 = counters held at (0,0)
//   h_cnt, v_cnt       : current raster position, active region first
//   active             : position lies inside the visible area
//   hsync_raw          : h_cnt inside the hsync window (polarity-free)
//   vsync_raw          : v_cnt inside the vsync window (whole lines)
//   frame_first        : position is (0,0)
//   frame_last         : position is (H_TOTAL-1, V_TOTAL-1)
import yolo_video_pkg::*;

module video_timing_counter #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        run,
  output logic [15:0] h_cnt,
  output logic [15:0] v_cnt,
  output logic        active,
  output logic        hsync_raw,
  output logic        vsync_raw,
  output logic        frame_first,
  output logic        frame_last
);

  localparam logic [15:0] H_LAST   = 16'(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [15:0] V_LAST   = 16'(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEGIN = 16'(sync_start(H_ACTIVE, H_FP));
  localparam logic [15:0] HS_END   = 16'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [15:0] VS_BEGIN = 16'(sync_start(V_ACTIVE, V_FP));
  localparam logic [15:0] VS_END   = 16'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
    end else begin
      h_cnt <= h_cnt + 16'd1;
    end
  end

  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_raw   = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vsync_raw   = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
  assign frame_first = (h_cnt == 16'd0) && (v_cnt == 16'd0);
  assign frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/yolo_video_tx.sv
// Transmit side of the RGB video interface: converts a ready/valid pixel
// stream into raster video with programmable timing, aligning each frame
// to the input start-of-frame marker.
// Ports:
//   sys_clk, sys_rst_n            : pixel clock, async active-low reset
//   en                            : run enable, sampled on the last frame cycle
//   pix_data_i/valid_i/sof_i      : input pixel stream (sof qualified by valid)
//   pix_ready_o                   : pixel accepted when ready && valid
//   rgb_o, hsync_o, vsync_o, de_o : registered video, 1 clock behind counters
//   hcount_o, vcount_o            : raster position of the current rgb_o
//   underflow_o                   : pulse, active pixel had no valid input
//   frame_err_o                   : pulse, SOF misalignment detected
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | counters held at 0, outputs at reset values, no pixels taken
// SYNC  | raster running, non-SOF pixels dropped, SOF held until (0,0)
// RUN   | raster running, one pixel consumed per active cycle
import yolo_video_pkg::*;

module yolo_video_tx #(
  parameter int                    DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int                    H_ACTIVE        = DEF_H_ACTIVE,
  parameter int                    H_FP            = DEF_H_FP,
  parameter int                    H_SYNC          = DEF_H_SYNC,
  parameter int                    H_BP            = DEF_H_BP,
  parameter int                    V_ACTIVE        = DEF_V_ACTIVE,
  parameter int                    V_FP            = DEF_V_FP,
  parameter int                    V_SYNC          = DEF_V_SYNC,
  parameter int                    V_BP            = DEF_V_BP,
  parameter logic                  HSYNC_POL       = 1'b0,
  parameter logic                  VSYNC_POL       = 1'b0,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = '0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  input  logic                  pix_valid_i,
  input  logic                  pix_sof_i,
  output logic                  pix_ready_o,
  output logic [DATA_WIDTH-1:0] rgb_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [15:0]           hcount_o,
  output logic [15:0]           vcount_o,
  output logic                  underflow_o,
  output logic                  frame_err_o
);

  vtx_state_t  state;
  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        active;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        frame_first;
  logic        frame_last;

  logic        misalign;
  logic        sof_take;
  logic        pix_take;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .run         (state != ST_IDLE),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  // Misalignment is only judged on active cycles: a SOF waiting through
  // blanking for the next (0,0) is the normal case, not an error.
  always_comb begin
    misalign    = 1'b0;
    sof_take    = 1'b0;
    pix_take    = 1'b0;
    pix_ready_o = 1'b0;
    case (state)
      ST_SYNC: begin
        pix_ready_o = !(pix_valid_i && pix_sof_i) || frame_first;
        sof_take    = pix_valid_i && pix_sof_i && frame_first;
      end
      ST_RUN: begin
        misalign    = active && pix_valid_i && (pix_sof_i != frame_first);
        pix_ready_o = active && !misalign;
        pix_take    = active && pix_valid_i && !misalign;
      end
      default: begin
        pix_ready_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      rgb_o       <= '0;
      de_o        <= 1'b0;
      hsync_o     <= ~HSYNC_POL;
      vsync_o     <= ~VSYNC_POL;
      hcount_o    <= '0;
      vcount_o    <= '0;
      underflow_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rgb_o       <= '0;
          de_o        <= 1'b0;
          hsync_o     <= ~HSYNC_POL;
          vsync_o     <= ~VSYNC_POL;
          hcount_o    <= '0;
          vcount_o    <= '0;
          underflow_o <= 1'b0;
          frame_err_o <= 1'b0;
          if (en) state <= ST_SYNC;
        end
        ST_SYNC, ST_RUN: begin
          rgb_o       <= (sof_take || pix_take) ? pix_data_i : UNDERFLOW_COLOR;
          de_o        <= active;
          hsync_o     <= hsync_raw ? HSYNC_POL : ~HSYNC_POL;
          vsync_o     <= vsync_raw ? VSYNC_POL : ~VSYNC_POL;
          hcount_o    <= h_cnt;
          vcount_o    <= v_cnt;
          underflow_o <= (state == ST_RUN) && active && !pix_valid_i;
          frame_err_o <= misalign;
          if (sof_take)                state <= ST_RUN;
          else if (misalign)           state <= ST_SYNC;
          else if (frame_last && !en)  state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yolo_video_tx.sv
module tb_yolo_video_tx;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        en;
  logic [15:0] pix_data_i;
  logic        pix_valid_i;
  logic        pix_sof_i;
  logic        pix_ready_o;
  logic [15:0] rgb_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic [15:0] hcount_o;
  logic [15:0] vcount_o;
  logic        underflow_o;
  logic        frame_err_o;

  yolo_video_tx #(
    .DATA_WIDTH(16), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .UNDERFLOW_COLOR(16'h0000)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
    .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_sof_i(pix_sof_i),
    .pix_ready_o(pix_ready_o), .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .de_o(de_o), .hcount_o(hcount_o), .vcount_o(vcount_o),
    .underflow_o(underflow_o), .frame_err_o(frame_err_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] rgb;
    logic        de, hs, vs;
    logic [15:0] hc, vc;
    logic        uf, fe;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    int          gap;
  } pix_t;

  exp_t        expq[$];
  pix_t        src[$];
  logic [15:0] cap[$];
  logic [15:0] want[$];

  int n_checks = 0;
  int n_errors = 0;
  int uf_cnt   = 0;
  int fe_cnt   = 0;
  bit cap_on   = 0;

  // Reference raster/stream model: 0 idle, 1 sync, 2 run
  int m_st = 0;
  int m_h  = 0;
  int m_v  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.rgb = 16'h0; e.de = 0; e.hs = 1; e.vs = 1;
    e.hc = 16'h0; e.vc = 16'h0; e.uf = 0; e.fe = 0;
    return e;
  endfunction

  function automatic logic m_ready();
    bit act, first;
    act   = (m_h < HA) && (m_v < VA);
    first = (m_h == 0) && (m_v == 0);
    case (m_st)
      1:       return !(pix_valid_i && pix_sof_i) || first;
      2:       return act && !(pix_valid_i && (pix_sof_i != first));
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_inputs();
    if (src.size() > 0 && src[0].gap == 0) begin
      pix_valid_i = 1'b1;
      pix_data_i  = src[0].data;
      pix_sof_i   = src[0].sof;
    end else begin
      pix_valid_i = 1'b0;
      pix_data_i  = 16'h0;
      pix_sof_i   = 1'b0;
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit act, first, last, bad, acc, take, v, s;
    if (!sys_rst_n) begin
      m_st = 0; m_h = 0; m_v = 0;
      expq.push_back(reset_exp());
      return;
    end
    v     = pix_valid_i;
    s     = pix_sof_i;
    act   = (m_h < HA) && (m_v < VA);
    first = (m_h == 0) && (m_v == 0);
    last  = (m_h == HT - 1) && (m_v == VT - 1);
    acc   = v && m_ready();
    if (m_st == 0) begin
      e = reset_exp();
      if (en) m_st = 1;
    end else begin
      bad  = (m_st == 2) && v && act && (s != first);
      take = acc && !(m_st == 1 && !s);
      e.rgb = take ? pix_data_i : 16'h0;
      e.de  = act;
      e.hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
      e.vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
      e.hc  = 16'(m_h);
      e.vc  = 16'(m_v);
      e.uf  = (m_st == 2) && act && !v;
      e.fe  = bad;
      if (m_st == 1 && take)  m_st = 2;
      else if (bad)           m_st = 1;
      else if (last && !en)   m_st = 0;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    if (acc) void'(src.pop_front());
    else if (src.size() > 0 && src[0].gap > 0) src[0].gap--;
    expq.push_back(e);
  endtask

  // One clock: check at negedge, advance model at posedge, drive at +1.
  task automatic tick();
    exp_t e;
    @(negedge sys_clk);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("rgb",    32'(rgb_o),       32'(e.rgb));
      chk("de",     32'(de_o),        32'(e.de));
      chk("hsync",  32'(hsync_o),     32'(e.hs));
      chk("vsync",  32'(vsync_o),     32'(e.vs));
      chk("hcount", 32'(hcount_o),    32'(e.hc));
      chk("vcount", 32'(vcount_o),    32'(e.vc));
      chk("uflow",  32'(underflow_o), 32'(e.uf));
      chk("ferr",   32'(frame_err_o), 32'(e.fe));
    end
    chk("ready", 32'(pix_ready_o), 32'(m_ready()));
    if (cap_on && de_o) cap.push_back(rgb_o);
    uf_cnt += int'(underflow_o);
    fe_cnt += int'(frame_err_o);
    @(posedge sys_clk);
    model_step();
    #1;
    drive_inputs();
  endtask

  task automatic push_frame(input logic [15:0] base, input int n, input int gap_idx, input int gap_len);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.data = base + 16'(i);
      p.sof  = (i == 0);
      p.gap  = (i == gap_idx) ? gap_len : 0;
      src.push_back(p);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_rgb"},   32'(rgb_o),       32'h0);
    chk({pfx, "_de"},    32'(de_o),        32'h0);
    chk({pfx, "_hsync"}, 32'(hsync_o),     32'h1);
    chk({pfx, "_vsync"}, 32'(vsync_o),     32'h1);
    chk({pfx, "_hcnt"},  32'(hcount_o),    32'h0);
    chk({pfx, "_vcnt"},  32'(vcount_o),    32'h0);
    chk({pfx, "_ready"}, 32'(pix_ready_o), 32'h0);
    chk({pfx, "_uf"},    32'(underflow_o), 32'h0);
    chk({pfx, "_fe"},    32'(frame_err_o), 32'h0);
  endtask

  task automatic compare_capture(input string tag);
    chk({tag, "_count_ok"}, 32'(cap.size() >= want.size()), 32'h1);
    for (int i = 0; i < want.size(); i++) begin
      if (i < cap.size()) chk(tag, 32'(cap[i]), 32'(want[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waited;
    bit  found;
    sys_rst_n   = 1'b0;
    en          = 1'b0;
    pix_valid_i = 1'b0;
    pix_data_i  = 16'h0;
    pix_sof_i   = 1'b0;

    repeat (3) tick();
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;

    // Frames: A plain, B with a 2-clock gap at pixel 6, C broken by an
    // early SOF (D0 at x=1,y=1), D realigned; en drops mid-frame D.
    push_frame(16'h0001, 12, -1, 0);
    push_frame(16'h0101, 10,  5, 2);
    push_frame(16'h0201,  5, -1, 0);
    push_frame(16'h0301, 12, -1, 0);
    en     = 1'b1;
    cap_on = 1'b1;
    drive_inputs();

    waited = 0;
    while (src.size() > 6 && waited < 400) begin tick(); waited++; end
    chk("reach_mid_d", 32'(src.size() <= 6), 32'h1);
    en = 1'b0;
    waited = 0;
    while (src.size() > 0 && waited < 200) begin tick(); waited++; end
    chk("src_drained", 32'(src.size()), 32'h0);
    repeat (60) tick();

    for (int i = 0; i < 12; i++) want.push_back(16'h0001 + 16'(i));
    for (int i = 0; i < 5; i++)  want.push_back(16'h0101 + 16'(i));
    want.push_back(16'h0); want.push_back(16'h0);
    for (int i = 5; i < 10; i++) want.push_back(16'h0101 + 16'(i));
    for (int i = 0; i < 5; i++)  want.push_back(16'h0201 + 16'(i));
    for (int i = 0; i < 7; i++)  want.push_back(16'h0);
    for (int i = 0; i < 12; i++) want.push_back(16'h0301 + 16'(i));
    compare_capture("pix_main");
    chk("pix_main_size", 32'(cap.size()), 32'd48);
    chk("uf_total", 32'(uf_cnt), 32'd2);
    chk("fe_total", 32'(fe_cnt), 32'd1);
    chk("idle_de",    32'(de_o),        32'h0);
    chk("idle_ready", 32'(pix_ready_o), 32'h0);
    chk("idle_hsync", 32'(hsync_o),     32'h1);
    chk("idle_vsync", 32'(vsync_o),     32'h1);

    // Restart and hit reset while hsync is asserted.
    en = 1'b1;
    found  = 0;
    waited = 0;
    while (!found && waited < 200) begin
      tick();
      waited++;
      if (hsync_o == 1'b0 && hcount_o == 16'(HA + HF)) found = 1;
    end
    chk("hsync_seen", 32'(found), 32'h1);
    chk("hs_before_rst", 32'(hsync_o), 32'h0);
    sys_rst_n = 1'b0;
    m_st = 0; m_h = 0; m_v = 0;
    expq.delete();
    #1;
    check_reset_outputs("async_rst");
    repeat (2) tick();

    // After release: three stray pixels dropped, SOF frame aligned.
    cap.delete();
    want.delete();
    begin
      pix_t p;
      for (int i = 0; i < 3; i++) begin
        p.data = 16'h0A01 + 16'(i); p.sof = 1'b0; p.gap = 0;
        src.push_back(p);
      end
    end
    push_frame(16'h0E01, 12, -1, 0);
    sys_rst_n = 1'b1;
    drive_inputs();
    waited = 0;
    while (src.size() > 0 && waited < 300) begin tick(); waited++; end
    chk("src2_drained", 32'(src.size()), 32'h0);
    repeat (5) tick();
    for (int i = 0; i < 12; i++) want.push_back(16'h0);
    for (int i = 0; i < 12; i++) want.push_back(16'h0E01 + 16'(i));
    compare_capture("pix_resync");
    chk("fe_after_resync", 32'(fe_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
